// File: rtl/lamp_monitor.sv
// Traffic-lamp monitor: drives lamps from the upstream phase code and flashes yellow on faults.
// Optional LAMP_TEST_EN adds a lamp_test input forcing all lamps on (registered).
module lamp_monitor #(
  parameter int FLASH_DIV = 4,
  parameter int MIN_DWELL = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] light,
  input  logic       clear_fault,
`ifdef LAMP_TEST_EN
  input  logic       lamp_test,
`endif
  output logic       red_lamp,
  output logic       yellow_lamp,
  output logic       green_lamp,
  output logic       fault,
  output logic [1:0] fault_cause
);

  localparam logic [0:0] NORMAL = 1'b0;
  localparam logic [0:0] FAULT  = 1'b1;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;
  localparam logic [1:0] BAD    = 2'b11;

  localparam logic [7:0] DWELL_MIN  = 8'(MIN_DWELL);
  localparam logic [7:0] FLASH_LAST = 8'(FLASH_DIV - 1);

  logic [0:0] mode_reg, mode_next;
  logic [1:0] prev_light_reg;
  logic [7:0] dwell_cnt_reg, dwell_cnt_next;
  logic [7:0] flash_cnt_reg, flash_cnt_next;
  logic       lamp_r_reg, lamp_r_next;
  logic       lamp_y_reg, lamp_y_next;
  logic       lamp_g_reg, lamp_g_next;
  logic       fault_reg, fault_next;
  logic [1:0] cause_reg, cause_next;

  logic       change;
  logic       legal_step;
  logic [1:0] det_cause;
  logic       fault_det;

  assign change     = (light != prev_light_reg);
  assign legal_step = (prev_light_reg == RED    && light == GREEN)  ||
                      (prev_light_reg == GREEN  && light == YELLOW) ||
                      (prev_light_reg == YELLOW && light == RED);

  // Priority: illegal code, then illegal change, then dwell violation.
  always_comb begin
    det_cause = 2'b00;
    if (light == BAD)
      det_cause = 2'b11;
    else if (change && !legal_step)
      det_cause = 2'b01;
    else if (change && (dwell_cnt_reg < DWELL_MIN))
      det_cause = 2'b10;
  end

  assign fault_det = (det_cause != 2'b00);

  always_comb begin
    if (change)
      dwell_cnt_next = 8'd1;
    else if (dwell_cnt_reg >= DWELL_MIN)
      dwell_cnt_next = DWELL_MIN;
    else
      dwell_cnt_next = dwell_cnt_reg + 8'd1;
  end

  always_comb begin
    mode_next      = mode_reg;
    flash_cnt_next = flash_cnt_reg;
    lamp_r_next    = lamp_r_reg;
    lamp_y_next    = lamp_y_reg;
    lamp_g_next    = lamp_g_reg;
    fault_next     = fault_reg;
    cause_next     = cause_reg;
    case (mode_reg)
      NORMAL: begin
        if (fault_det) begin
          mode_next      = FAULT;
          fault_next     = 1'b1;
          cause_next     = det_cause;
          flash_cnt_next = 8'd0;
          lamp_r_next    = 1'b0;
          lamp_y_next    = 1'b1;
          lamp_g_next    = 1'b0;
        end else begin
          lamp_r_next = (light == RED);
          lamp_y_next = (light == YELLOW);
          lamp_g_next = (light == GREEN);
        end
      end
      FAULT: begin
        lamp_r_next = 1'b0;
        lamp_g_next = 1'b0;
        if (clear_fault && light == RED && !fault_det) begin
          mode_next      = NORMAL;
          fault_next     = 1'b0;
          cause_next     = 2'b00;
          flash_cnt_next = 8'd0;
          lamp_r_next    = 1'b1;
          lamp_y_next    = 1'b0;
        end else if (flash_cnt_reg >= FLASH_LAST) begin
          flash_cnt_next = 8'd0;
          lamp_y_next    = ~lamp_y_reg;
        end else begin
          flash_cnt_next = flash_cnt_reg + 8'd1;
        end
      end
      default: mode_next = NORMAL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_reg       <= NORMAL;
      prev_light_reg <= RED;
      dwell_cnt_reg  <= DWELL_MIN;
      flash_cnt_reg  <= 8'd0;
      lamp_r_reg     <= 1'b1;
      lamp_y_reg     <= 1'b0;
      lamp_g_reg     <= 1'b0;
      fault_reg      <= 1'b0;
      cause_reg      <= 2'b00;
    end else begin
      mode_reg       <= mode_next;
      prev_light_reg <= light;
      dwell_cnt_reg  <= dwell_cnt_next;
      flash_cnt_reg  <= flash_cnt_next;
      lamp_r_reg     <= lamp_r_next;
      lamp_y_reg     <= lamp_y_next;
      lamp_g_reg     <= lamp_g_next;
      fault_reg      <= fault_next;
      cause_reg      <= cause_next;
    end
  end

  assign fault       = fault_reg;
  assign fault_cause = cause_reg;

`ifdef LAMP_TEST_EN
  // Lamp test overrides only the output stage; the mode lamps (and flashing) keep running underneath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red_lamp    <= 1'b1;
      yellow_lamp <= 1'b0;
      green_lamp  <= 1'b0;
    end else begin
      red_lamp    <= lamp_test | lamp_r_next;
      yellow_lamp <= lamp_test | lamp_y_next;
      green_lamp  <= lamp_test | lamp_g_next;
    end
  end
`else
  assign red_lamp    = lamp_r_reg;
  assign yellow_lamp = lamp_y_reg;
  assign green_lamp  = lamp_g_reg;
`endif

endmodule

// File: doc/lamp_monitor.md
LAMP_MONITOR -- requirements
Module: lamp_monitor

Interface
REQ-001 Parameter FLASH_DIV, default 4, cycles per yellow flash half-period in fault mode (legal range 1..255).
REQ-002 Parameter MIN_DWELL, default 1, minimum cycles a light code is held before a change (legal range 1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 light  input  2  phase code from upstream controller: RED=00, YELLOW=01, GREEN=10; 11 is illegal.
REQ-006 clear_fault  input  1  one-cycle request to leave fault mode.
REQ-007 red_lamp / yellow_lamp / green_lamp  output  1 each  registered lamp drives.
REQ-008 fault  output  1  registered; high while in fault mode.
REQ-009 fault_cause  output  2  registered first-fault cause: 00 none, 01 illegal transition, 10 dwell violation, 11 illegal code.

Function
REQ-010 Two modes: NORMAL, FAULT; transitions only on clk rising edge.
REQ-011 NORMAL: lamps are the one-hot decode of light, registered, latency 1 cycle (RED->red_lamp, YELLOW->yellow_lamp, GREEN->green_lamp).
REQ-012 Internal prev_light holds the code sampled in the previous cycle; dwell_cnt counts consecutive cycles the current code has been sampled, saturating at MIN_DWELL.
REQ-013 Change = light != prev_light; on change, dwell_cnt loads 1; otherwise it increments (saturating).
REQ-014 Legal changes only: RED->GREEN, GREEN->YELLOW, YELLOW->RED; holding the same code is always legal.
REQ-015 Fault detected in a cycle: light==11 (cause 11), else illegal change (cause 01), else change with dwell_cnt < MIN_DWELL (cause 10); priority in that order.
REQ-016 Fault detected in NORMAL: next cycle fault=1, fault_cause=detected cause, red/green lamps 0, yellow_lamp 1, flash counter 0.
REQ-017 FAULT: flash counter counts 0..FLASH_DIV-1, wraps, and yellow_lamp toggles on each wrap; red/green stay 0.
REQ-018 FAULT: prev_light and dwell_cnt keep tracking; further faults neither change fault_cause nor restart flashing.
REQ-019 clear_fault honoured only when light==RED and no fault detected that cycle; next cycle: NORMAL, fault=0, fault_cause=00, red_lamp=1.
REQ-020 clear_fault with light!=RED, or coinciding with a fault detection, is ignored (fault stays, cause unchanged).
REQ-021 clear_fault in NORMAL has no effect.

Reset
REQ-022 Reset asserted: immediately red_lamp=1, yellow_lamp=0, green_lamp=0, fault=0, fault_cause=00, mode NORMAL.
REQ-023 Reset sets prev_light=RED, dwell_cnt=MIN_DWELL, flash counter 0, so first post-reset RED->GREEN is legal.
REQ-024 Reset mid-FAULT aborts fault mode with no state retained.

Configuration
REQ-025 Macro LAMP_TEST_EN defined: adds input lamp_test (1 bit); while high all three lamps are driven 1 (registered, 1-cycle latency) in either mode; monitoring, fault and fault_cause unaffected; on release lamps resume mode behaviour next cycle.
REQ-026 Macro LAMP_TEST_EN undefined: no lamp_test port; behaviour exactly as REQ-010..REQ-024.

Verification
REQ-027 Reset, then light RED,GREEN,YELLOW,RED one cycle each -> lamps 100,001,010,100 (r,y,g) one cycle delayed, fault=0.
REQ-028 RED then GREEN then RED -> fault=1, fault_cause=01, yellow toggles every 4 cycles (FLASH_DIV=4), red/green 0.
REQ-029 MIN_DWELL=3: RED 3 cycles, GREEN 1 cycle, YELLOW -> fault_cause=10 on cycle after YELLOW sampled.
REQ-030 light=11 in NORMAL -> fault_cause=11; in FAULT, clear_fault with light=GREEN ignored; with light=RED -> fault=0, cause 00, red_lamp=1 next cycle.
REQ-031 Reset asserted mid-FAULT between clock edges -> outputs 100, fault=0, cause 00 without waiting for clk; with LAMP_TEST_EN, lamp_test=1 during FAULT -> lamps 111, fault stays 1.
